// File: rtl/bp_resolve_pkg.sv
// Shared sizing constants and FSM encoding for the branch-prediction resolve unit.
package bp_resolve_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned BP_DEPTH    = 4;
    localparam int unsigned CNT_W       = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_fifo.sv
// Generic DEPTH x WIDTH circular FIFO; head is presented combinationally on dout.
module bp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Extra pointer MSB separates full from empty when the indices coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/bp_resolve.sv
// Resolves fetch-stage static predictions against EX outcomes; flushes and redirects on mispredict.
module bp_resolve
    import bp_resolve_pkg::*;
#(
    parameter int unsigned DEPTH = BP_DEPTH,
    parameter int unsigned AW    = INST_ADDR_W,
    parameter int unsigned CW    = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_valid_i,
    input  logic [AW-1:0] pred_pc_i,
    input  logic          pred_taken_i,
    input  logic [AW-1:0] pred_target_i,
    input  logic          ex_valid_i,
    input  logic [AW-1:0] ex_pc_i,
    input  logic          ex_taken_i,
    input  logic [AW-1:0] ex_target_i,
    input  logic          hold_i,
    output logic          full_o,
    output logic          flush_o,
    output logic [AW-1:0] redirect_addr_o,
    output logic          seq_err_o,
    output logic [CW-1:0] br_cnt_o,
    output logic [CW-1:0] mispred_cnt_o
);

    localparam int unsigned   EW      = 2 * AW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    bp_state_t     state;
    bp_state_t     state_nxt;
    logic [EW-1:0] head;
    logic [AW-1:0] head_pc;
    logic          head_taken;
    logic [AW-1:0] head_target;
    logic          empty;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;
    logic          mispred;
    logic          flush_nxt;
    logic [AW-1:0] redirect_nxt;
    logic          seq_err_nxt;
    logic [CW-1:0] br_nxt;
    logic [CW-1:0] mp_nxt;

    bp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .clear (mispred),
        .din   ({pred_pc_i, pred_taken_i, pred_target_i}),
        .dout  (head),
        .full  (fifo_full),
        .empty (empty)
    );

    assign head_pc     = head[2*AW:AW+1];
    assign head_taken  = head[AW];
    assign head_target = head[AW-1:0];
    assign full_o      = fifo_full;

    always_comb begin
        state_nxt    = state;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        mispred      = 1'b0;
        flush_nxt    = 1'b0;
        redirect_nxt = redirect_addr_o;
        seq_err_nxt  = seq_err_o;
        br_nxt       = br_cnt_o;
        mp_nxt       = mispred_cnt_o;
        case (state)
            RUN: begin
                if (!hold_i) begin
                    if (ex_valid_i) begin
                        if (empty) begin
                            seq_err_nxt = 1'b1;
                        end else begin
                            do_pop = 1'b1;
                            if (head_pc != ex_pc_i) seq_err_nxt = 1'b1;
                            if (br_cnt_o != CNT_MAX) br_nxt = br_cnt_o + CW'(1);
                            mispred = (head_taken != ex_taken_i) ||
                                      (head_taken && ex_taken_i && (head_target != ex_target_i));
                            if (mispred) begin
                                if (mispred_cnt_o != CNT_MAX) mp_nxt = mispred_cnt_o + CW'(1);
                                redirect_nxt = ex_taken_i ? ex_target_i : ex_pc_i + AW'(4);
                                flush_nxt    = 1'b1;
                                state_nxt    = FLUSH;
                            end
                        end
                    end
                    // Younger predictions are wrong-path once this pop mispredicts.
                    if (pred_valid_i && !mispred) begin
                        if (!fifo_full || do_pop) do_push = 1'b1;
                        else                      seq_err_nxt = 1'b1;
                    end
                end
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            flush_o         <= 1'b0;
            redirect_addr_o <= '0;
            seq_err_o       <= 1'b0;
            br_cnt_o        <= '0;
            mispred_cnt_o   <= '0;
        end else begin
            state           <= state_nxt;
            flush_o         <= flush_nxt;
            redirect_addr_o <= redirect_nxt;
            seq_err_o       <= seq_err_nxt;
            br_cnt_o        <= br_nxt;
            mispred_cnt_o   <= mp_nxt;
        end
    end

endmodule

// File: tb/tb_bp_resolve.sv
// Directed plus random checks of bp_resolve against a queue-based reference model.
module tb_bp_resolve;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned CW    = 6;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic [AW-1:0] pc;
        logic          tk;
        logic [AW-1:0] tg;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid_i;
    logic [AW-1:0] pred_pc_i;
    logic          pred_taken_i;
    logic [AW-1:0] pred_target_i;
    logic          ex_valid_i;
    logic [AW-1:0] ex_pc_i;
    logic          ex_taken_i;
    logic [AW-1:0] ex_target_i;
    logic          hold_i;
    logic          full_o;
    logic          flush_o;
    logic [AW-1:0] redirect_addr_o;
    logic          seq_err_o;
    logic [CW-1:0] br_cnt_o;
    logic [CW-1:0] mispred_cnt_o;

    bp_resolve #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_taken_i    (pred_taken_i),
        .pred_target_i   (pred_target_i),
        .ex_valid_i      (ex_valid_i),
        .ex_pc_i         (ex_pc_i),
        .ex_taken_i      (ex_taken_i),
        .ex_target_i     (ex_target_i),
        .hold_i          (hold_i),
        .full_o          (full_o),
        .flush_o         (flush_o),
        .redirect_addr_o (redirect_addr_o),
        .seq_err_o       (seq_err_o),
        .br_cnt_o        (br_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference state: outstanding predictions in program order plus observable registers.
    ent_t          q[$];
    logic          m_flush;
    logic          m_err;
    logic [AW-1:0] m_redir;
    logic [CW-1:0] m_br;
    logic [CW-1:0] m_mp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 1'b0;
        m_err   = 1'b0;
        m_redir = '0;
        m_br    = '0;
        m_mp    = '0;
    endtask

    task automatic model_step();
        ent_t h;
        logic mis;
        mis = 1'b0;
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (!hold_i) begin
            if (ex_valid_i) begin
                if (q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h = q.pop_front();
                    if (h.pc != ex_pc_i) m_err = 1'b1;
                    if (m_br != CMAX) m_br = m_br + CW'(1);
                    mis = (h.tk != ex_taken_i) || (h.tk && ex_taken_i && (h.tg != ex_target_i));
                    if (mis) begin
                        if (m_mp != CMAX) m_mp = m_mp + CW'(1);
                        m_redir = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
                        q.delete();
                        m_flush = 1'b1;
                    end
                end
            end
            if (pred_valid_i && !mis) begin
                if (q.size() < int'(DEPTH)) begin
                    h.pc = pred_pc_i;
                    h.tk = pred_taken_i;
                    h.tg = pred_target_i;
                    q.push_back(h);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/flush"},   64'(flush_o),         64'(m_flush));
        chk({tag, "/redir"},   64'(redirect_addr_o), 64'(m_redir));
        chk({tag, "/seq_err"}, 64'(seq_err_o),       64'(m_err));
        chk({tag, "/br"},      64'(br_cnt_o),        64'(m_br));
        chk({tag, "/mp"},      64'(mispred_cnt_o),   64'(m_mp));
        chk({tag, "/full"},    64'(full_o),          64'(q.size() == int'(DEPTH)));
    endtask

    // Called at a negedge: drive one cycle, advance the model, check at the next negedge.
    task automatic drive_cycle(input logic pv, input logic [AW-1:0] ppc, input logic ptk,
                               input logic [AW-1:0] ptg, input logic ev, input logic [AW-1:0] epc,
                               input logic etk, input logic [AW-1:0] etg, input logic hd,
                               input string tag);
        pred_valid_i  = pv;
        pred_pc_i     = ppc;
        pred_taken_i  = ptk;
        pred_target_i = ptg;
        ex_valid_i    = ev;
        ex_pc_i       = epc;
        ex_taken_i    = etk;
        ex_target_i   = etg;
        hold_i        = hd;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg, input string tag);
        drive_cycle(1'b1, pc, tk, tg, 1'b0, '0, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic resolve(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg, input string tag);
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, pc, tk, tg, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        pred_valid_i = 1'b0;
        ex_valid_i   = 1'b0;
        hold_i       = 1'b0;
        rst          = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic          r_pv, r_ptk, r_ev, r_etk, r_hd;
    logic [AW-1:0] r_ppc, r_ptg, r_epc, r_etg;
    logic [AW-1:0] next_pc;

    initial begin
        rst = 1'b1;
        pred_valid_i = 1'b0; pred_pc_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
        ex_valid_i = 1'b0; ex_pc_i = '0; ex_taken_i = 1'b0; ex_target_i = '0; hold_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("por");
        chk("por_redir", 64'(redirect_addr_o), 64'h0);
        rst = 1'b0;

        // Correct taken prediction
        push(32'h100, 1'b1, 32'h140, "t1_push");
        resolve(32'h100, 1'b1, 32'h140, "t1_ex");
        chk("t1_br", 64'(br_cnt_o), 64'd1);
        chk("t1_mp", 64'(mispred_cnt_o), 64'd0);
        chk("t1_flush", 64'(flush_o), 64'd0);

        // Direction mispredict discards the younger entry
        push(32'h200, 1'b0, 32'h0, "t2_push0");
        push(32'h204, 1'b0, 32'h0, "t2_push1");
        resolve(32'h200, 1'b1, 32'h1F0, "t2_ex");
        chk("t2_flush", 64'(flush_o), 64'd1);
        chk("t2_redir", 64'(redirect_addr_o), 64'h1F0);
        idle("t2_idle");
        chk("t2_flush_end", 64'(flush_o), 64'd0);
        push(32'h208, 1'b0, 32'h0, "t2_push2");
        resolve(32'h208, 1'b0, 32'h0, "t2_ex2");
        chk("t2_seq_err", 64'(seq_err_o), 64'd0);
        chk("t2_mp", 64'(mispred_cnt_o), 64'd1);

        // Predicted taken, resolved not-taken
        push(32'h300, 1'b1, 32'h380, "t3_push");
        resolve(32'h300, 1'b0, 32'h0, "t3_ex");
        chk("t3_flush", 64'(flush_o), 64'd1);
        chk("t3_redir", 64'(redirect_addr_o), 64'h304);
        idle("t3_idle");

        // Full queue with simultaneous push/pop, then overflow
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 1'b0, 32'h0, "t4_fill");
        chk("t4_full", 64'(full_o), 64'd1);
        drive_cycle(1'b1, 32'h410, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, "t4_pushpop");
        chk("t4_full2", 64'(full_o), 64'd1);
        chk("t4_seq_ok", 64'(seq_err_o), 64'd0);
        push(32'h414, 1'b0, 32'h0, "t4_overflow");
        chk("t4_seq_err", 64'(seq_err_o), 64'd1);
        do_reset("t4_rst");

        // Pop on empty, then PC mismatch
        resolve(32'h500, 1'b0, 32'h0, "t5_empty");
        chk("t5_seq_err", 64'(seq_err_o), 64'd1);
        chk("t5_br", 64'(br_cnt_o), 64'd0);
        chk("t5_flush", 64'(flush_o), 64'd0);
        do_reset("t5_rst");
        push(32'h504, 1'b0, 32'h0, "t5_push");
        resolve(32'h500, 1'b0, 32'h0, "t5_pcerr");
        chk("t5_pc_err", 64'(seq_err_o), 64'd1);
        do_reset("t5_rst2");

        // Hold suppresses pop; reset during FLUSH
        push(32'h600, 1'b0, 32'h0, "t6_push");
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, 32'h600, 1'b0, '0, 1'b1, "t6_hold");
        chk("t6_hold_br", 64'(br_cnt_o), 64'd0);
        resolve(32'h600, 1'b0, 32'h0, "t6_ex");
        chk("t6_br", 64'(br_cnt_o), 64'd1);
        push(32'h700, 1'b0, 32'h0, "t6_push2");
        resolve(32'h700, 1'b1, 32'h780, "t6_mis");
        chk("t6_in_flush", 64'(flush_o), 64'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_flush", 64'(flush_o), 64'd0);
        chk("t6_rst_br", 64'(br_cnt_o), 64'd0);
        chk("t6_rst_mp", 64'(mispred_cnt_o), 64'd0);
        chk("t6_rst_full", 64'(full_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle("t6_after");

        // Random traffic, mostly well-formed, with occasional protocol violations
        next_pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            r_pv  = ($urandom % 2) == 0;
            if (q.size() >= int'(DEPTH) && ($urandom % 20) != 0) r_pv = 1'b0;
            r_ppc = next_pc;
            r_ptk = ($urandom % 2) == 0;
            r_ptg = 32'($urandom) & 32'hFFFF_FFFC;
            r_ev  = ($urandom % 3) != 0;
            r_epc = 32'($urandom);
            r_etk = ($urandom % 2) == 0;
            r_etg = 32'($urandom);
            if (q.size() == 0) begin
                if (($urandom % 20) != 0) r_ev = 1'b0;
            end else begin
                r_epc = (($urandom % 25) == 0) ? q[0].pc + 32'd4 : q[0].pc;
                r_etk = (($urandom % 5) == 0) ? ~q[0].tk : q[0].tk;
                r_etg = (($urandom % 6) == 0) ? 32'($urandom) : q[0].tg;
            end
            r_hd = ($urandom % 8) == 0;
            if (r_pv) next_pc = next_pc + 32'd4;
            if (($urandom % 300) == 0) begin
                do_reset("rnd_rst");
            end else begin
                drive_cycle(r_pv, r_ppc, r_ptk, r_ptg, r_ev, r_epc, r_etk, r_etg, r_hd, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_resolve.md
Name: bp_resolve

Overview:
- Execute-side counterpart of the fetch-stage static predictor.
- Records every prediction made at fetch, in program order, for B-type and JAL instructions.
- When EX resolves that instruction, compares the actual outcome with the recorded prediction.
- On a mismatch, issues a one-cycle pipeline flush and a redirect PC, and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4: prediction queue entries; power of two, at least 2.
- AW, 32: instruction address width; matches `InstAddrBus`.
- CW, 32: width of each statistics counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- pred_valid_i  input  1  fetch issued a B/JAL prediction this cycle.
- pred_pc_i  input  AW  PC of the predicted instruction.
- pred_taken_i  input  1  predicted direction.
- pred_target_i  input  AW  predicted target; don't-care when not taken.
- ex_valid_i  input  1  EX resolves a B/JAL instruction this cycle.
- ex_pc_i  input  AW  PC of the resolving instruction.
- ex_taken_i  input  1  actual direction.
- ex_target_i  input  AW  actual taken target.
- hold_i  input  1  pipeline stall; suppresses push, pop and counting.
- full_o  input/output: output  1  queue full; fetch must stall predictions.
- flush_o  output  1  registered one-cycle flush pulse.
- redirect_addr_o  output  AW  correct next PC; valid while flush_o is high.
- seq_err_o  output  1  sticky protocol-error flag.
- br_cnt_o  output  CW  number of resolved branches.
- mispred_cnt_o  output  CW  number of mispredictions.

Behaviour:
Reset values:
- On rst high, asynchronously: queue empty, full_o=0, flush_o=0, redirect_addr_o=`ZeroWord`, seq_err_o=0, both counters=0, FSM=RUN.

Queue:
- Circular FIFO, DEPTH entries of {pc, taken, target}.
- Read/write pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Pointers wrap modulo 2*DEPTH.
- full_o is combinational from the pointers.

Push (at posedge):
- Condition: pred_valid_i & ~hold_i & state==RUN & (~full | pop).
- A simultaneous pop when full is allowed and frees the slot for the push in the same edge.
- pred_valid_i while full with no pop: the prediction is dropped and seq_err_o is set. Fetch must never do this.

Pop (at posedge):
- Condition: ex_valid_i & ~hold_i & state==RUN.
- The head entry is compared against the EX outcome combinationally.

Mispredict when either:
- head.taken != ex_taken_i, or
- head.taken & ex_taken_i & (head.target != ex_target_i).

Sequence checks:
- Pop on empty: seq_err_o set, no flush, br_cnt_o not incremented.
- head.pc != ex_pc_i: seq_err_o set; the comparison still proceeds normally.

Correct prediction:
- br_cnt_o increments.
- No other visible effect.

Mispredict:
- br_cnt_o and mispred_cnt_o both increment.
- Next cycle: flush_o=1 and redirect_addr_o = ex_taken_i ? ex_target_i : ex_pc_i + 4 (AW-bit add, wraps).
- Same edge: the queue is cleared (both pointers reset). All younger entries are wrong-path.
- A push arriving in that same cycle is discarded.

FSM:
- RUN -> FLUSH on a mispredicting pop.
- FLUSH -> RUN unconditionally after one cycle. flush_o is high only in FLUSH.
- In FLUSH, pred_valid_i and ex_valid_i are ignored (wrong-path) and hold_i has no effect.
- redirect_addr_o holds its value after FLUSH until the next mispredict.

Counters:
- Saturate at all-ones; they do not wrap.
- A mispredict at saturation still flushes.

Other rules:
- hold_i: freezes the queue, counters and FSM state RUN; flush_o stays 0.
- seq_err_o: cleared only by rst.
- Reset mid-FLUSH: flush_o drops immediately (async) and the queue is empty.
- Latency: mispredicting EX cycle N -> flush_o in cycle N+1, exactly one cycle wide.

Decomposition:
- Shared constants stay in defines.v: `InstAddrBus`, `ZeroWord`, `JumpEnable`/`JumpDisable`.
- Add `BpDepth` (4) and the FSM encodings RUN=1'b0, FLUSH=1'b1 to defines.v.
- One sub-module, bp_fifo:
  - generic DEPTH x WIDTH synchronous FIFO with async active-high reset;
  - ports push, pop, clear, din, dout (head), full, empty.
- bp_resolve contains the compare logic, FSM, redirect register and counters.

Test Plan:
1. Correct prediction:
   - Stimulus: push {pc=0x100, taken=1, target=0x140}; next cycle EX {0x100, taken=1, 0x140}.
   - Required: flush_o stays 0; br_cnt=1, mispred_cnt=0; queue empty.
2. Direction mispredict:
   - Stimulus: push {0x200, taken=0}, then {0x204, taken=0}; EX {0x200, taken=1, target=0x1F0}.
   - Required: next cycle flush_o=1 and redirect=0x1F0 for one cycle; queue empty (0x204 entry discarded); mispred_cnt=1.
3. Predicted taken, resolved not-taken:
   - Stimulus: push {0x300, taken=1, 0x380}; EX {0x300, taken=0}.
   - Required: redirect=0x304, flush_o pulse.
4. Full and simultaneous push/pop:
   - Stimulus: push 4 entries; full_o=1; then push+pop in the same cycle with a correct outcome.
   - Required: full_o stays 1, entry count stays 4, seq_err_o=0.
   - Then push alone while full. Required: seq_err_o=1.
5. Errors:
   - Stimulus: EX pop on an empty queue.
   - Required: seq_err_o=1, no flush, br_cnt unchanged.
   - Stimulus: EX pc 0x500 vs head pc 0x504.
   - Required: seq_err_o=1.
6. Hold and reset:
   - Stimulus: ex_valid_i with hold_i=1.
   - Required: no pop, no count change.
   - Stimulus: assert rst during FLUSH.
   - Required: flush_o=0 immediately; counters 0; queue empty.
